// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq
//   Streams N-byte operands LSB-first through an external 8-bit adder
//   (hybridadder8_struct). Drives the adder's Xi/Yi/C0 for each byte, captures
//   Si/C8 into a one-entry output register, and chains the carry from byte to
//   byte. Subtraction is two's complement: Y is inverted and the first byte
//   gets a carry-in of 1.
//
// Parameters
//   MAX_BYTES   maximum bytes per operation. When the last allowed byte
//               arrives without in_last_i, it is closed as the final byte
//               and out_err_o is set.
//
// Optional feature (macro ZERO_FLAG_EN)
//   Adds out_zero_o: set together with out_last_o when every result byte of
//   the operation was 0x00. Without the macro, the port and its logic are
//   absent.
//
// Ports
//   clk_i, rst_n_i           clock (rising edge) and async active-low reset
//   in_valid_i / in_ready_o  input byte-pair handshake
//   in_x_i, in_y_i           operand bytes, LSB first
//   in_last_i                marks the MSB byte of an operation
//   in_sub_i                 subtract select, sampled on the first byte only
//   add_x_o, add_y_o, add_cin_o   to adder Xi / Yi / C0
//   add_sum_i, add_cout_i         from adder Si / C8
//   out_valid_o / out_ready_i     result byte handshake
//   out_sum_o                     result byte
//   out_last_o                    final byte of the operation
//   out_cout_o, out_ovf_o         final carry and signed overflow (with last)
//   out_err_o                     closed at MAX_BYTES without in_last_i
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_FIRST | next accepted byte starts a new operation (uses in_sub_i)
// ST_MID   | inside an operation; carry and sub chained from registers
module multibyte_add_seq #(
  parameter int MAX_BYTES = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_x_i,
  input  logic [7:0] in_y_i,
  input  logic       in_last_i,
  input  logic       in_sub_i,
  output logic [7:0] add_x_o,
  output logic [7:0] add_y_o,
  output logic       add_cin_o,
  input  logic [7:0] add_sum_i,
  input  logic       add_cout_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_sum_o,
  output logic       out_last_o,
  output logic       out_cout_o,
  output logic       out_ovf_o,
`ifdef ZERO_FLAG_EN
  output logic       out_zero_o,
`endif
  output logic       out_err_o
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BYTES - 1);

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_sum_q, out_sum_d;
  logic             out_last_q, out_last_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_err_q, out_err_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  logic is_first;
  logic sub_eff;
  logic accept;
  logic at_limit;
  logic is_last;

  assign is_first = (state_q == ST_FIRST);
  assign sub_eff  = is_first ? in_sub_i : sub_q;

  // Adder operands are purely combinational so the adder settles within the
  // accepting cycle and its result is registered on that same edge.
  assign add_x_o   = in_x_i;
  assign add_y_o   = in_y_i ^ {8{sub_eff}};
  assign add_cin_o = is_first ? in_sub_i : carry_q;

  // One-entry output register: a new byte may enter in the same cycle the
  // held one is taken, so there is no bubble.
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  assign at_limit = (byte_cnt_q == LAST_IDX);
  assign is_last  = in_last_i || at_limit;

`ifdef ZERO_FLAG_EN
  logic out_zero_q, out_zero_d;
  logic zero_acc_q, zero_acc_d;
  logic zero_all;

  // The accumulator is ignored on a first byte, so it restarts at each
  // operation without needing an explicit clear cycle.
  assign zero_all = (is_first || zero_acc_q) && (add_sum_i == 8'h00);
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    out_err_d   = out_err_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    byte_cnt_d  = byte_cnt_q;
`ifdef ZERO_FLAG_EN
    out_zero_d  = out_zero_q;
    zero_acc_d  = zero_acc_q;
`endif

    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_sum_i;
      if (is_first) begin
        sub_d = in_sub_i;
      end
      if (is_last) begin
        out_last_d = 1'b1;
        out_cout_d = add_cout_i;
        // Signed overflow: both adder operands share a sign that the
        // result does not.
        out_ovf_d  = (in_x_i[7] == add_y_o[7]) && (add_sum_i[7] != in_x_i[7]);
        out_err_d  = !in_last_i;
        carry_d    = 1'b0;
        byte_cnt_d = '0;
        state_d    = ST_FIRST;
`ifdef ZERO_FLAG_EN
        out_zero_d = zero_all;
        zero_acc_d = 1'b0;
`endif
      end else begin
        out_last_d = 1'b0;
        out_cout_d = 1'b0;
        out_ovf_d  = 1'b0;
        out_err_d  = 1'b0;
        carry_d    = add_cout_i;
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        state_d    = ST_MID;
`ifdef ZERO_FLAG_EN
        out_zero_d = 1'b0;
        zero_acc_d = zero_all;
`endif
      end
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_FIRST;
      out_valid_q <= 1'b0;
      out_sum_q   <= 8'h00;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      byte_cnt_q  <= '0;
`ifdef ZERO_FLAG_EN
      out_zero_q  <= 1'b0;
      zero_acc_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      byte_cnt_q  <= byte_cnt_d;
`ifdef ZERO_FLAG_EN
      out_zero_q  <= out_zero_d;
      zero_acc_q  <= zero_acc_d;
`endif
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_sum_o   = out_sum_q;
  assign out_last_o  = out_last_q;
  assign out_cout_o  = out_cout_q;
  assign out_ovf_o   = out_ovf_q;
  assign out_err_o   = out_err_q;
`ifdef ZERO_FLAG_EN
  assign out_zero_o  = out_zero_q;
`endif

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Testbench for multibyte_add_seq. The external 8-bit adder is stood in for by
// a behavioural sum of add_x + add_y + add_cin; all expected results below are
// worked out by hand from the operands. Inputs change on the falling edge;
// registered outputs are sampled 1 time unit after the rising edge.
module tb_multibyte_add_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic       in_last;
  logic       in_sub;
  logic [7:0] add_x;
  logic [7:0] add_y;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_last;
  logic       out_cout;
  logic       out_ovf;
  logic       out_err;
`ifdef ZERO_FLAG_EN
  logic       out_zero;
`endif

  int checks = 0;
  int errors = 0;

  multibyte_add_seq #(.MAX_BYTES(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_x_i      (in_x),
    .in_y_i      (in_y),
    .in_last_i   (in_last),
    .in_sub_i    (in_sub),
    .add_x_o     (add_x),
    .add_y_o     (add_y),
    .add_cin_o   (add_cin),
    .add_sum_i   (add_sum),
    .add_cout_i  (add_cout),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .out_last_o  (out_last),
    .out_cout_o  (out_cout),
    .out_ovf_o   (out_ovf),
`ifdef ZERO_FLAG_EN
    .out_zero_o  (out_zero),
`endif
    .out_err_o   (out_err)
  );

  // Behavioural stand-in for the 8-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {8'h00, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] x, input logic [7:0] y,
                       input logic last, input logic sub);
    @(negedge clk);
    in_x     = x;
    in_y     = y;
    in_last  = last;
    in_sub   = sub;
    in_valid = 1'b1;
  endtask

  task automatic clock_in();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    in_sub = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++;
    if (out_sum !== 8'h00) begin errors++; $display("FAIL reset_out_sum: got %h exp 00", out_sum); end
    checks++;
    if ({out_last, out_cout, out_ovf, out_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b exp 0000", {out_last, out_cout, out_ovf, out_err});
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++;
    if (add_cin !== 1'b1) begin errors++; $display("FAIL reset_add_cin: got %b exp 1", add_cin); end
    @(negedge clk);
    rst_n  = 1'b1;
    in_sub = 1'b0;
  endtask

  // 0x01FF + 0x0001 = 0x0200
  task automatic test_add_2byte();
    drive(8'hFF, 8'h01, 1'b0, 1'b0);
    clock_in();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'h00) begin
      errors++; $display("FAIL add2_b0: got valid %b sum %h exp 1 00", out_valid, out_sum);
    end
    checks++;
    if (out_last !== 1'b0) begin errors++; $display("FAIL add2_b0_last: got %b exp 0", out_last); end
    drive(8'h01, 8'h00, 1'b1, 1'b0);
    #1;
    checks++;
    if (add_cin !== 1'b1) begin errors++; $display("FAIL add2_chain_cin: got %b exp 1", add_cin); end
    clock_in();
    checks++;
    if (out_sum !== 8'h02 || out_last !== 1'b1) begin
      errors++; $display("FAIL add2_b1: got sum %h last %b exp 02 1", out_sum, out_last);
    end
    checks++;
    if ({out_cout, out_ovf, out_err} !== 3'b000) begin
      errors++; $display("FAIL add2_b1_flags: got %b exp 000", {out_cout, out_ovf, out_err});
    end
  endtask

  task automatic test_sub_1byte();
    // 0x05 - 0x07 = 0xFE, borrow (cout 0), no overflow
    drive(8'h05, 8'h07, 1'b1, 1'b1);
    #1;
    checks++;
    if (add_y !== 8'hF8 || add_cin !== 1'b1) begin
      errors++; $display("FAIL sub1_adder_in: got y %h cin %b exp F8 1", add_y, add_cin);
    end
    clock_in();
    checks++;
    if (out_sum !== 8'hFE || out_last !== 1'b1) begin
      errors++; $display("FAIL sub1_sum: got sum %h last %b exp FE 1", out_sum, out_last);
    end
    checks++;
    if (out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      errors++; $display("FAIL sub1_flags: got cout %b ovf %b exp 0 0", out_cout, out_ovf);
    end
    // 0x80 - 0x01 = 0x7F, signed overflow, no borrow
    drive(8'h80, 8'h01, 1'b1, 1'b1);
    clock_in();
    checks++;
    if (out_sum !== 8'h7F) begin errors++; $display("FAIL sub2_sum: got %h exp 7F", out_sum); end
    checks++;
    if (out_ovf !== 1'b1 || out_cout !== 1'b1) begin
      errors++; $display("FAIL sub2_flags: got ovf %b cout %b exp 1 1", out_ovf, out_cout);
    end
  endtask

  // 0xFFFF + 0x0001 with the downstream stalled after the first byte
  task automatic test_stall();
    out_ready = 1'b1;
    drive(8'hFF, 8'h01, 1'b0, 1'b0);
    clock_in();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(8'hFF, 8'h00, 1'b1, 1'b0);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b exp 0", i, in_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'h00 || out_last !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: got valid %b sum %h last %b exp 1 00 0", i, out_valid, out_sum, out_last);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || add_cin !== 1'b1) begin
      errors++; $display("FAIL stall_release: got in_ready %b cin %b exp 1 1", in_ready, add_cin);
    end
    clock_in();
    checks++;
    if (out_sum !== 8'h00 || out_last !== 1'b1 || out_cout !== 1'b1) begin
      errors++; $display("FAIL stall_b1: got sum %h last %b cout %b exp 00 1 1", out_sum, out_last, out_cout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b exp 0", out_valid); end
  endtask

  // Eight bytes with no in_last: the eighth is forced last with an error.
  task automatic test_max_bytes();
    for (int i = 0; i < 8; i++) begin
      drive(8'h01, 8'h01, 1'b0, 1'b0);
      clock_in();
      checks++;
      if (out_sum !== 8'h02 || out_last !== (i == 7) || out_err !== (i == 7)) begin
        errors++; $display("FAIL max_b%0d: got sum %h last %b err %b exp 02 %0d %0d",
                           i, out_sum, out_last, out_err, (i == 7), (i == 7));
      end
    end
    // Ninth byte: fresh op, 0x03 - 0x01
    drive(8'h03, 8'h01, 1'b1, 1'b1);
    #1;
    checks++;
    if (add_cin !== 1'b1 || add_y !== 8'hFE) begin
      errors++; $display("FAIL max_fresh_in: got cin %b y %h exp 1 FE", add_cin, add_y);
    end
    clock_in();
    checks++;
    if (out_sum !== 8'h02 || out_last !== 1'b1 || out_err !== 1'b0 || out_cout !== 1'b1) begin
      errors++; $display("FAIL max_fresh_out: got sum %h last %b err %b cout %b exp 02 1 0 1",
                         out_sum, out_last, out_err, out_cout);
    end
  endtask

  task automatic test_reset_mid();
    drive(8'hFF, 8'hFF, 1'b0, 1'b0);
    clock_in();
    checks++;
    if (out_sum !== 8'hFE) begin errors++; $display("FAIL rmid_b0: got %h exp FE", out_sum); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 8'h00) begin
      errors++; $display("FAIL rmid_async: got valid %b sum %h exp 0 00", out_valid, out_sum);
    end
    #2;
    rst_n = 1'b1;
    drive(8'h01, 8'h01, 1'b1, 1'b0);
    #1;
    checks++;
    if (add_cin !== 1'b0) begin errors++; $display("FAIL rmid_cin: got %b exp 0", add_cin); end
    clock_in();
    checks++;
    if (out_sum !== 8'h02 || out_last !== 1'b1 || out_err !== 1'b0) begin
      errors++; $display("FAIL rmid_next: got sum %h last %b err %b exp 02 1 0", out_sum, out_last, out_err);
    end
  endtask

  // Two ops streamed on consecutive cycles: 0x1234 + 0x0F0F, then 0x7F + 0x01.
  task automatic test_back_to_back();
    drive(8'h34, 8'h0F, 1'b0, 1'b0);
    clock_in();
    checks++;
    if (out_sum !== 8'h43) begin errors++; $display("FAIL b2b_b0: got %h exp 43", out_sum); end
    drive(8'h12, 8'h0F, 1'b1, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", in_ready); end
    clock_in();
    checks++;
    if (out_sum !== 8'h21 || out_last !== 1'b1) begin
      errors++; $display("FAIL b2b_b1: got sum %h last %b exp 21 1", out_sum, out_last);
    end
    drive(8'h7F, 8'h01, 1'b1, 1'b0);
    clock_in();
    checks++;
    if (out_sum !== 8'h80 || out_ovf !== 1'b1 || out_cout !== 1'b0) begin
      errors++; $display("FAIL b2b_op2: got sum %h ovf %b cout %b exp 80 1 0", out_sum, out_ovf, out_cout);
    end
  endtask

`ifdef ZERO_FLAG_EN
  task automatic test_zero_flag();
    // 0x0100 - 0x0100
    drive(8'h00, 8'h00, 1'b0, 1'b1);
    clock_in();
    checks++;
    if (out_sum !== 8'h00 || out_zero !== 1'b0) begin
      errors++; $display("FAIL zero_b0: got sum %h zero %b exp 00 0", out_sum, out_zero);
    end
    drive(8'h01, 8'h01, 1'b1, 1'b0);
    clock_in();
    checks++;
    if (out_sum !== 8'h00 || out_zero !== 1'b1 || out_last !== 1'b1) begin
      errors++; $display("FAIL zero_b1: got sum %h zero %b last %b exp 00 1 1", out_sum, out_zero, out_last);
    end
    // 0x0001 + 0x0000
    drive(8'h01, 8'h00, 1'b0, 1'b0);
    clock_in();
    drive(8'h00, 8'h00, 1'b1, 1'b0);
    clock_in();
    checks++;
    if (out_sum !== 8'h00 || out_zero !== 1'b0) begin
      errors++; $display("FAIL nonzero_b1: got sum %h zero %b exp 00 0", out_sum, out_zero);
    end
  endtask
`endif

  initial begin
    in_valid  = 1'b0;
    in_x      = 8'h00;
    in_y      = 8'h00;
    in_last   = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    test_reset();
    test_add_2byte();
    test_sub_1byte();
    test_stall();
    test_max_bytes();
    test_reset_mid();
    test_back_to_back();
`ifdef ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
- Sequential operand sequencer directly upstream/downstream of the 8-bit hybrid adder (hybridadder8_struct).
- Streams N-byte operands LSB-first, drives the adder's Xi/Yi/C0 each byte, captures Si/C8, and chains the carry between bytes.
- Supports add and subtract (two's complement) of operands up to MAX_BYTES bytes; results leave on a valid/ready byte stream with final carry, overflow and error status.

Parameters:
- MAX_BYTES, 8, maximum bytes per operation; byte counter width = clog2(MAX_BYTES+1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input byte pair valid
- in_ready  out  1  block accepts input byte pair
- in_x  in  8  operand X byte
- in_y  in  8  operand Y byte
- in_last  in  1  marks MSB byte of operation
- in_sub  in  1  subtract select; sampled on first byte only
- add_x  out  8  to adder Xi
- add_y  out  8  to adder Yi
- add_cin  out  1  to adder C0
- add_sum  in  8  from adder Si
- add_cout  in  1  from adder C8
- out_valid  out  1  result byte valid
- out_ready  in  1  downstream accepts result byte
- out_sum  out  8  result byte
- out_last  out  1  final byte of operation
- out_cout  out  1  final carry (valid with out_last, else 0)
- out_ovf  out  1  signed overflow (valid with out_last, else 0)
- out_err  out  1  MAX_BYTES reached without in_last (with out_last)

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_sum=0, out_last=0, out_cout=0, out_ovf=0, out_err=0, carry_q=0, sub_q=0, byte_cnt=0, state=FIRST.
- Adder path combinational: add_x=in_x; add_y=in_y XOR {8{sub_eff}}; add_cin = (state==FIRST) ? in_sub : carry_q; sub_eff = (state==FIRST) ? in_sub : sub_q.
- in_ready = !out_valid || out_ready (one-entry output register; full throughput, no bubble).
- Accept = in_valid && in_ready. On accept: out_sum<=add_sum, out_valid<=1, carry_q<=add_cout, byte_cnt++. Latency 1 cycle input-to-output.
- If out_valid && out_ready && !accept: out_valid<=0 next cycle.
- States: FIRST (next byte starts operation; latch sub_q<=in_sub on accept, go MID unless last); MID (chained bytes). Last byte (in_last, or byte_cnt==MAX_BYTES-1): out_last<=1, out_cout<=add_cout, out_ovf<=(in_x[7]==add_y[7]) && (add_sum[7]!=in_x[7]), carry_q<=0, byte_cnt<=0, state<=FIRST.
- Forced last: byte_cnt==MAX_BYTES-1 with in_last=0 -> treated as last, out_err<=1; following bytes begin a new operation.
- Non-last bytes: out_last, out_cout, out_ovf, out_err = 0.
- Single-byte operation (in_last on first byte): FIRST -> FIRST, uses in_sub directly.
- Output stall: out_valid && !out_ready holds all out_* stable, in_ready=0, state/carry unchanged.
- in_valid low mid-operation: carry_q, sub_q, byte_cnt held indefinitely.
- Reset mid-operation: partial result discarded, all state to reset values.

Optional Feature:
- Macro ZERO_FLAG_EN. Defined: extra output out_zero (1 bit), =1 with out_last iff every result byte of the operation was 0x00 (sticky-AND register cleared at FIRST, reset 0); 0 on non-last bytes. Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- 2-byte add 0x01FF + 0x0001, in_sub=0 -> bytes 0x00 then 0x02, out_last on 2nd, out_cout=0, out_ovf=0.
- 1-byte sub 0x05 - 0x07, in_last=1 -> out_sum=0xFE, out_cout=0 (borrow), out_ovf=0; 0x80-0x01 -> 0x7F, out_ovf=1.
- 2-byte add 0xFFFF + 0x0001 with out_ready low 3 cycles after first byte -> in_ready=0 during stall, bytes 0x00,0x00 preserved, out_cout=1.
- MAX_BYTES=8, 8 bytes with in_last never set -> 8th byte has out_last=1, out_err=1; 9th byte starts fresh with add_cin=in_sub.
- rst_n pulsed low after 1st byte of 3-byte op -> outputs zero immediately; next byte treated as FIRST with add_cin=in_sub.
- ZERO_FLAG_EN: 0x0100 - 0x0100 -> bytes 0x00,0x00, out_zero=1 on last; 0x0001+0x0000 -> out_zero=0.
